gmm_dma_cfg_writer: RTL and testbench

Downstream stage of the GMM DMA descriptor/prefetcher setup logic. It accepts that logic's fire-and-forget write pulses and issues them as Avalon-MM writes. Descriptor writes (256-bit) go to the prefetcher descriptor memory; CSR writes (32-bit) go to the prefetcher CSR slave. It buffers both streams against waitrequest backpressure. It guarantees that no CSR write (including the run bit) reaches the prefetcher before every previously received descriptor write has been accepted.

---
 rtl/gmm_dma_cfg_writer.sv | 162 ++++++++++++++++
 tb/tb_gmm_dma_cfg_writer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmm_dma_cfg_writer.sv
// Issues buffered descriptor (256-bit) and CSR (32-bit) writes as Avalon-MM writes.
// A CSR write is never issued while any earlier descriptor write is still outstanding.
module gmm_dma_cfg_writer #(
  parameter int DESC_DEPTH = 16,
  parameter int CSR_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ram_write,
  input  logic [255:0] ram_writedata,
  input  logic [5:0]   ram_addr,
  input  logic         pref_write,
  input  logic [31:0]  pref_writedata,
  input  logic [2:0]   pref_addr,
  output logic         desc_write,
  output logic [5:0]   desc_address,
  output logic [255:0] desc_writedata,
  output logic [31:0]  desc_byteenable,
  input  logic         desc_waitrequest,
  output logic         csr_write,
  output logic [2:0]   csr_address,
  output logic [31:0]  csr_writedata,
  output logic [3:0]   csr_byteenable,
  input  logic         csr_waitrequest,
  output logic         busy,
  output logic         overflow,
  output logic [7:0]   desc_count
);

  localparam int DAW = $clog2(DESC_DEPTH);
  localparam int CAW = $clog2(CSR_DEPTH);
  localparam logic [DAW:0] DESC_FULL = (DAW+1)'(DESC_DEPTH);
  localparam logic [DAW:0] DESC_ONE  = (DAW+1)'(1);
  localparam logic [CAW:0] CSR_FULL  = (CAW+1)'(CSR_DEPTH);
  localparam logic [CAW:0] CSR_ONE   = (CAW+1)'(1);

  typedef enum logic {D_IDLE, D_ISSUE} desc_state_t;
  typedef enum logic [1:0] {C_IDLE, C_WAIT_DESC, C_ISSUE} csr_state_t;

  // Descriptor channel storage; the bus registers hold a copy of the head entry.
  logic [261:0]   desc_mem [DESC_DEPTH];
  logic [DAW-1:0] desc_wr_ptr, desc_rd_ptr, desc_rd_next;
  logic [DAW:0]   desc_cnt;
  logic           desc_accept, desc_push;
  desc_state_t    desc_state;

  logic [34:0]    csr_mem [CSR_DEPTH];
  logic [CAW-1:0] csr_wr_ptr, csr_rd_ptr, csr_rd_next;
  logic [CAW:0]   csr_cnt;
  logic           csr_accept, csr_push;
  csr_state_t     csr_state;

  assign desc_accept  = desc_write & ~desc_waitrequest;
  assign desc_push    = ram_write & ((desc_cnt != DESC_FULL) | desc_accept);
  assign desc_rd_next = desc_rd_ptr + 1'b1;

  assign csr_accept   = csr_write & ~csr_waitrequest;
  assign csr_push     = pref_write & ((csr_cnt != CSR_FULL) | csr_accept);
  assign csr_rd_next  = csr_rd_ptr + 1'b1;

  assign desc_byteenable = {32{desc_write}};
  assign csr_byteenable  = {4{csr_write}};
  assign busy = (desc_cnt != '0) | (csr_cnt != '0) | desc_write | csr_write;

  // NOTE: storage arrays carry no reset; the counts and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (desc_push) desc_mem[desc_wr_ptr] <= {ram_addr, ram_writedata};
    if (csr_push)  csr_mem[csr_wr_ptr]   <= {pref_addr, pref_writedata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_wr_ptr <= '0;
      desc_cnt    <= '0;
      csr_wr_ptr  <= '0;
      csr_cnt     <= '0;
      overflow    <= 1'b0;
      desc_count  <= '0;
    end else begin
      if (desc_push) desc_wr_ptr <= desc_wr_ptr + 1'b1;
      if (csr_push)  csr_wr_ptr  <= csr_wr_ptr + 1'b1;
      case ({desc_push, desc_accept})
        2'b10:   desc_cnt <= desc_cnt + 1'b1;
        2'b01:   desc_cnt <= desc_cnt - 1'b1;
        default: desc_cnt <= desc_cnt;
      endcase
      case ({csr_push, csr_accept})
        2'b10:   csr_cnt <= csr_cnt + 1'b1;
        2'b01:   csr_cnt <= csr_cnt - 1'b1;
        default: csr_cnt <= csr_cnt;
      endcase
      if ((ram_write & ~desc_push) | (pref_write & ~csr_push)) overflow <= 1'b1;
      if (desc_accept && desc_count != 8'hFF) desc_count <= desc_count + 1'b1;
    end
  end

  // Descriptor issue FSM: on accept, the next stored entry loads in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_state     <= D_IDLE;
      desc_rd_ptr    <= '0;
      desc_write     <= 1'b0;
      desc_address   <= '0;
      desc_writedata <= '0;
    end else begin
      case (desc_state)
        D_IDLE: begin
          if (desc_cnt != '0) begin
            desc_state                     <= D_ISSUE;
            desc_write                     <= 1'b1;
            {desc_address, desc_writedata} <= desc_mem[desc_rd_ptr];
          end
        end
        D_ISSUE: begin
          if (desc_accept) begin
            desc_rd_ptr <= desc_rd_next;
            if (desc_cnt > DESC_ONE) begin
              {desc_address, desc_writedata} <= desc_mem[desc_rd_next];
            end else begin
              desc_state <= D_IDLE;
              desc_write <= 1'b0;
            end
          end
        end
        default: desc_state <= D_IDLE;
      endcase
    end
  end

  // CSR issue FSM: each CSR write waits until the descriptor channel has fully drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_state     <= C_IDLE;
      csr_rd_ptr    <= '0;
      csr_write     <= 1'b0;
      csr_address   <= '0;
      csr_writedata <= '0;
    end else begin
      case (csr_state)
        C_IDLE: begin
          if (csr_cnt != '0) csr_state <= C_WAIT_DESC;
        end
        C_WAIT_DESC: begin
          if (desc_cnt == '0 && !desc_write) begin
            csr_state                    <= C_ISSUE;
            csr_write                    <= 1'b1;
            {csr_address, csr_writedata} <= csr_mem[csr_rd_ptr];
          end
        end
        C_ISSUE: begin
          if (csr_accept) begin
            csr_rd_ptr <= csr_rd_next;
            csr_write  <= 1'b0;
            csr_state  <= (csr_cnt > CSR_ONE) ? C_WAIT_DESC : C_IDLE;
          end
        end
        default: csr_state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmm_dma_cfg_writer.sv
// Self-checking bench for gmm_dma_cfg_writer: directed scenarios plus randomized traffic
// checked against a transaction-level queue model of both write channels.
module tb_gmm_dma_cfg_writer;

  localparam int DD = 16;
  localparam int CD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ram_write = 1'b0;
  logic [255:0] ram_writedata = '0;
  logic [5:0]   ram_addr = '0;
  logic         pref_write = 1'b0;
  logic [31:0]  pref_writedata = '0;
  logic [2:0]   pref_addr = '0;
  logic         desc_write;
  logic [5:0]   desc_address;
  logic [255:0] desc_writedata;
  logic [31:0]  desc_byteenable;
  logic         desc_waitrequest = 1'b0;
  logic         csr_write;
  logic [2:0]   csr_address;
  logic [31:0]  csr_writedata;
  logic [3:0]   csr_byteenable;
  logic         csr_waitrequest = 1'b0;
  logic         busy;
  logic         overflow;
  logic [7:0]   desc_count;

  gmm_dma_cfg_writer #(.DESC_DEPTH(DD), .CSR_DEPTH(CD)) dut (
    .clk(clk), .rst(rst),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_addr(ram_addr),
    .pref_write(pref_write), .pref_writedata(pref_writedata), .pref_addr(pref_addr),
    .desc_write(desc_write), .desc_address(desc_address), .desc_writedata(desc_writedata),
    .desc_byteenable(desc_byteenable), .desc_waitrequest(desc_waitrequest),
    .csr_write(csr_write), .csr_address(csr_address), .csr_writedata(csr_writedata),
    .csr_byteenable(csr_byteenable), .csr_waitrequest(csr_waitrequest),
    .busy(busy), .overflow(overflow), .desc_count(desc_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] addr; logic [255:0] data; } desc_t;
  typedef struct { logic [2:0] addr; logic [31:0] data; int desc_before; } csr_t;

  desc_t        dq[$];
  csr_t         cq[$];
  int           csr_log[$];
  logic [31:0]  csr_last_data;
  int           desc_pushed = 0;
  int           desc_acc = 0;
  bit           exp_ovf = 1'b0;
  bit           model_on = 1'b0;
  bit           d_stall_prev = 1'b0, c_stall_prev = 1'b0;
  logic [5:0]   pd_addr;
  logic [255:0] pd_data;
  logic [2:0]   pc_addr;
  logic [31:0]  pc_data;
  int           n_assert = 0;
  int           n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    dq.delete();
    cq.delete();
    desc_pushed  = 0;
    desc_acc     = 0;
    exp_ovf      = 1'b0;
    d_stall_prev = 1'b0;
    c_stall_prev = 1'b0;
  endtask

  // Evaluated mid-cycle: the inputs and bus state seen here decide what the next edge does.
  task automatic model_eval();
    chk("overflow", overflow, exp_ovf);
    chk("desc_count", desc_count, (desc_acc > 255) ? 255 : desc_acc);
    chk("busy", busy, (dq.size() != 0 || cq.size() != 0));
    chk("desc_byteenable", desc_byteenable, desc_write ? 32'hFFFF_FFFF : 32'h0);
    chk("csr_byteenable", csr_byteenable, csr_write ? 4'hF : 4'h0);
    if (d_stall_prev) begin
      chk("desc_hold_write", desc_write, 1'b1);
      chk("desc_hold_addr", desc_address, pd_addr);
      chk("desc_hold_data", desc_writedata, pd_data);
    end
    if (c_stall_prev) begin
      chk("csr_hold_write", csr_write, 1'b1);
      chk("csr_hold_addr", csr_address, pc_addr);
      chk("csr_hold_data", csr_writedata, pc_data);
    end
    if (csr_write && !csr_waitrequest) begin
      if (cq.size() == 0) chk("csr_spurious_write", csr_write, 1'b0);
      else begin
        csr_t c = cq.pop_front();
        chk("csr_addr", csr_address, c.addr);
        chk("csr_data", csr_writedata, c.data);
        chk("csr_after_desc", desc_acc >= c.desc_before, 1'b1);
        csr_log.push_back(int'(csr_address));
        csr_last_data = csr_writedata;
      end
    end
    if (desc_write && !desc_waitrequest) begin
      if (dq.size() == 0) chk("desc_spurious_write", desc_write, 1'b0);
      else begin
        desc_t d = dq.pop_front();
        chk("desc_addr", desc_address, d.addr);
        chk("desc_data", desc_writedata, d.data);
        desc_acc++;
      end
    end
    if (ram_write) begin
      if (dq.size() >= DD) exp_ovf = 1'b1;
      else begin
        dq.push_back('{ram_addr, ram_writedata});
        desc_pushed++;
      end
    end
    if (pref_write) begin
      if (cq.size() >= CD) exp_ovf = 1'b1;
      else cq.push_back('{pref_addr, pref_writedata, desc_pushed});
    end
    d_stall_prev = desc_write && desc_waitrequest;
    c_stall_prev = csr_write && csr_waitrequest;
    pd_addr = desc_address;
    pd_data = desc_writedata;
    pc_addr = csr_address;
    pc_data = csr_writedata;
  endtask

  // One clock: model at the negedge, return 1 time unit after the posedge, clear pulses.
  task automatic step();
    @(negedge clk);
    if (model_on) model_eval();
    @(posedge clk);
    #1;
    ram_write  = 1'b0;
    pref_write = 1'b0;
  endtask

  task automatic set_desc(input logic [5:0] a, input logic [255:0] d);
    ram_write = 1'b1; ram_addr = a; ram_writedata = d;
  endtask

  task automatic set_csr(input logic [2:0] a, input logic [31:0] d);
    pref_write = 1'b1; pref_addr = a; pref_writedata = d;
  endtask

  task automatic drain(input string tag, input int budget);
    desc_waitrequest = 1'b0;
    csr_waitrequest  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dq.size() == 0 && cq.size() == 0 && !desc_write && !csr_write) break;
      step();
    end
    chk({tag, "_desc_drained"}, dq.size(), 0);
    chk({tag, "_csr_drained"}, cq.size(), 0);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  logic [255:0] td [4];

  initial begin
    // Reset values, checked while rst is held.
    rst = 1'b1;
    #3;
    chk("rst_desc_write", desc_write, 1'b0);
    chk("rst_desc_addr", desc_address, 6'd0);
    chk("rst_desc_data", desc_writedata, 256'd0);
    chk("rst_desc_be", desc_byteenable, 32'd0);
    chk("rst_csr_write", csr_write, 1'b0);
    chk("rst_csr_addr", csr_address, 3'd0);
    chk("rst_csr_data", csr_writedata, 32'd0);
    chk("rst_csr_be", csr_byteenable, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_desc_count", desc_count, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    model_on = 1'b1;

    // 1: back-to-back descriptor writes with no stall.
    for (int i = 0; i < 4; i++) begin
      set_desc(6'(i), rnd256());
      step();
      if (i == 0) chk("t1_latency", desc_write, 1'b0);
      else begin
        chk("t1_write", desc_write, 1'b1);
        chk("t1_addr", desc_address, 6'(i - 1));
      end
    end
    step();
    chk("t1_write_last", desc_write, 1'b1);
    chk("t1_addr_last", desc_address, 6'd3);
    step();
    chk("t1_idle", desc_write, 1'b0);
    chk("t1_count", desc_count, 8'd4);
    chk("t1_busy", busy, 1'b0);

    // 2: five-cycle stall on the second descriptor write.
    for (int i = 0; i < 4; i++) td[i] = rnd256();
    set_desc(6'd0, td[0]); step();
    set_desc(6'd1, td[1]); step();
    set_desc(6'd2, td[2]); step();
    chk("t2_addr1_on_bus", desc_address, 6'd1);
    desc_waitrequest = 1'b1;
    set_desc(6'd3, td[3]);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_write", desc_write, 1'b1);
      chk("t2_hold_addr", desc_address, 6'd1);
      chk("t2_hold_data", desc_writedata, td[1]);
    end
    drain("t2", 50);
    chk("t2_overflow", overflow, 1'b0);
    chk("t2_count", desc_count, 8'd8);

    // 3: CSR writes queued behind stalled descriptor writes.
    csr_log.delete();
    desc_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_desc(6'(i), rnd256());
      if (i == 0) set_csr(3'd2, 32'h0);
      if (i == 1) set_csr(3'd1, 32'h0);
      if (i == 2) set_csr(3'd0, 32'h11);
      step();
      chk("t3_csr_blocked", csr_write, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_csr_blocked_stall", csr_write, 1'b0);
    end
    desc_waitrequest = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (desc_acc < 12) chk("t3_csr_gated", csr_write, 1'b0);
      if (cq.size() == 0 && !csr_write && !desc_write) break;
      step();
    end
    chk("t3_csr_n", csr_log.size(), 3);
    if (csr_log.size() == 3) begin
      chk("t3_csr_a0", csr_log[0], 2);
      chk("t3_csr_a1", csr_log[1], 1);
      chk("t3_csr_a2", csr_log[2], 0);
    end
    chk("t3_csr_last_data", csr_last_data, 32'h11);
    drain("t3", 20);

    // 4: overflow on the 17th push into a stalled descriptor channel.
    desc_waitrequest = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_desc(6'(i), rnd256());
      step();
      chk("t4_overflow_edge", overflow, (i == 16) ? 1'b1 : 1'b0);
    end
    drain("t4", 60);
    chk("t4_count", desc_count, 8'd28);
    chk("t4_overflow_sticky", overflow, 1'b1);

    // 5: simultaneous descriptor and CSR push into an idle block.
    set_desc(6'd5, rnd256());
    set_csr(3'd3, 32'hA5);
    step();
    chk("t5_desc_pre", desc_write, 1'b0);
    step();
    chk("t5_desc_issue", desc_write, 1'b1);
    chk("t5_csr_held", csr_write, 1'b0);
    step();
    chk("t5_desc_done", desc_write, 1'b0);
    chk("t5_csr_not_yet", csr_write, 1'b0);
    step();
    chk("t5_csr_issue", csr_write, 1'b1);
    chk("t5_csr_addr", csr_address, 3'd3);
    drain("t5", 20);

    // 6: reset in the middle of a stalled transfer.
    desc_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_desc(6'(i + 8), rnd256());
      step();
    end
    chk("t6_in_flight", desc_write, 1'b1);
    #2;
    rst = 1'b1;
    model_on = 1'b0;
    #1;
    chk("t6_rst_desc_write", desc_write, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_count", desc_count, 8'd0);
    chk("t6_rst_overflow", overflow, 1'b0);
    chk("t6_rst_addr", desc_address, 6'd0);
    desc_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    model_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_no_write", desc_write, 1'b0);
      chk("t6_no_busy", busy, 1'b0);
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 45) set_desc(6'($urandom), rnd256());
      if ($urandom_range(0, 99) < 12) set_csr(3'($urandom), $urandom);
      desc_waitrequest = ($urandom_range(0, 99) < 30);
      csr_waitrequest  = ($urandom_range(0, 99) < 30);
      step();
    end
    drain("rand", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
